lcd_bus_arbiter: RTL and testbench

Sequencer and arbiter for the shared 8080-style parallel LCD write bus (cs_n, d_c_n, wr_n, 16-bit data). It sits between two requesters and the LCD pins. Requester 0 is the CPU command/register path. Requester 1 is the DMA pixel stream. It grants the bus round-robin per transaction and generates chip-select and write-strobe timing from parameters.

---
 rtl/lcd_bus_arbiter_if.sv | 26 ++
 rtl/lcd_bus_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_arbiter_if.sv
// Bundle of requester handshake signals and 8080-style LCD write pins shared
// between the two requesters, the arbiter and the panel.
interface lcd_bus_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_dc;
    logic [1:0]  req_last;
    logic [15:0] req_data0;
    logic [15:0] req_data1;
    logic [1:0]  grant;
    logic        busy;
    logic        lcd_cs_n;
    logic        lcd_d_c_n;
    logic        lcd_wr_n;
    logic [15:0] lcd_data;

    modport master (
        output req_valid, req_dc, req_last, req_data0, req_data1,
        input  req_ready, grant, busy, lcd_cs_n, lcd_d_c_n, lcd_wr_n, lcd_data
    );

    modport slave (
        input  req_valid, req_dc, req_last, req_data0, req_data1,
        output req_ready, grant, busy, lcd_cs_n, lcd_d_c_n, lcd_wr_n, lcd_data
    );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter and write-strobe sequencer for a shared 8080-style LCD
// bus; requester 0 is the CPU command path, requester 1 the DMA pixel stream.
module lcd_bus_arbiter #(
    parameter int CS_SETUP = 1,
    parameter int WR_LOW   = 2,
    parameter int WR_HIGH  = 2,
    parameter int CS_HOLD  = 1
) (
    input  logic              clk,
    input  logic              reset,
    lcd_bus_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOW,
        S_HIGH,
        S_WAIT,
        S_HOLD
    } state_t;

    // Counters load N-1 on state entry so the final cycle is the one at zero.
    localparam logic [3:0] SETUP_LD = 4'(CS_SETUP - 1);
    localparam logic [3:0] LOW_LD   = 4'(WR_LOW - 1);
    localparam logic [3:0] HIGH_LD  = 4'(WR_HIGH - 1);
    localparam logic [3:0] HOLD_LD  = 4'(CS_HOLD - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [1:0]  grant_reg, grant_next;
    logic        last_grant_reg, last_grant_next;
    logic        last_reg, last_next;
    logic        busy_reg, busy_next;
    logic        cs_n_reg, cs_n_next;
    logic        wr_n_reg, wr_n_next;
    logic        dc_reg, dc_next;
    logic [15:0] data_reg, data_next;

    logic        cnt_done;
    logic        ready_window;
    logic [1:0]  ready;
    logic [1:0]  xfer_vec;
    logic        xfer;
    logic [1:0]  pick;
    logic        own_dc;
    logic        own_last;
    logic [15:0] own_data;

    assign cnt_done = (cnt_reg == 4'd0);

    // Cycles in which the owner may hand over a beat.
    always_comb begin
        ready_window = 1'b0;
        case (state_reg)
            S_SETUP: ready_window = cnt_done;
            S_HIGH:  ready_window = cnt_done & ~last_reg;
            S_WAIT:  ready_window = 1'b1;
            default: ready_window = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign ready[gi]    = ready_window & grant_reg[gi];
            assign xfer_vec[gi] = bus.req_valid[gi] & ready[gi];
        end
    endgenerate

    assign xfer          = |xfer_vec;
    assign bus.req_ready = ready;

    assign own_dc   = grant_reg[1] ? bus.req_dc[1]   : bus.req_dc[0];
    assign own_last = grant_reg[1] ? bus.req_last[1] : bus.req_last[0];
    assign own_data = grant_reg[1] ? bus.req_data1   : bus.req_data0;

    // last_grant_reg: 1 = DMA owned the bus last, so a tie goes to the CPU.
    always_comb begin
        pick = 2'b00;
        case (bus.req_valid)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_grant_reg ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        last_next       = last_reg;
        dc_next         = dc_reg;
        data_next       = data_reg;
        cnt_next        = cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    state_next      = S_SETUP;
                    grant_next      = pick;
                    last_grant_next = pick[1];
                end
            end
            S_SETUP: begin
                if (cnt_done) begin
                    state_next = xfer ? S_LOW : S_WAIT;
                end
            end
            S_LOW: begin
                if (cnt_done) begin
                    state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                if (cnt_done) begin
                    if (last_reg) begin
                        state_next = S_HOLD;
                    end else begin
                        state_next = xfer ? S_LOW : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (xfer) begin
                    state_next = S_LOW;
                end
            end
            S_HOLD: begin
                if (cnt_done) begin
                    state_next = S_IDLE;
                    grant_next = 2'b00;
                end
            end
            default: begin
                state_next = S_IDLE;
                grant_next = 2'b00;
            end
        endcase

        if (xfer) begin
            data_next = own_data;
            dc_next   = own_dc;
            last_next = own_last;
        end

        if (state_next != state_reg) begin
            case (state_next)
                S_SETUP: cnt_next = SETUP_LD;
                S_LOW:   cnt_next = LOW_LD;
                S_HIGH:  cnt_next = HIGH_LD;
                S_HOLD:  cnt_next = HOLD_LD;
                default: cnt_next = 4'd0;
            endcase
        end else if (!cnt_done) begin
            cnt_next = cnt_reg - 4'd1;
        end
    end

    // Pin levels are registered and follow the state being entered.
    assign cs_n_next = (state_next == S_IDLE);
    assign busy_next = (state_next != S_IDLE);
    assign wr_n_next = (state_next != S_LOW);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 4'd0;
            grant_reg      <= 2'b00;
            last_grant_reg <= 1'b1;
            last_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            cs_n_reg       <= 1'b1;
            wr_n_reg       <= 1'b1;
            dc_reg         <= 1'b1;
            data_reg       <= 16'h0000;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            last_reg       <= last_next;
            busy_reg       <= busy_next;
            cs_n_reg       <= cs_n_next;
            wr_n_reg       <= wr_n_next;
            dc_reg         <= dc_next;
            data_reg       <= data_next;
        end
    end

    assign bus.grant     = grant_reg;
    assign bus.busy      = busy_reg;
    assign bus.lcd_cs_n  = cs_n_reg;
    assign bus.lcd_wr_n  = wr_n_reg;
    assign bus.lcd_d_c_n = dc_reg;
    assign bus.lcd_data  = data_reg;

    a_grant_onehot : assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_reg));
    a_ready_owner : assert property (@(posedge clk) disable iff (reset)
        (ready & ~grant_reg) == 2'b00);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: requester models feed beats, a monitor
// checks every wr_n rising edge and every cs_n frame against expected queues.
`timescale 1ns/1ps
module tb_lcd_bus_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lcd_bus_arbiter_if bus ();
    lcd_bus_arbiter_if bus2 ();

    lcd_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    lcd_bus_arbiter #(
        .CS_SETUP (3),
        .WR_LOW   (1),
        .WR_HIGH  (4),
        .CS_HOLD  (2)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct {
        logic        dc;
        logic [15:0] data;
        logic        last;
        int          gap;
    } beat_t;

    typedef struct {
        logic [1:0]  owner;
        logic        dc;
        logic [15:0] data;
        int          rise_gap;
    } exp_beat_t;

    typedef struct {
        logic [1:0] owner;
        int         cs_len;
    } exp_txn_t;

    beat_t     cpu_q[$];
    beat_t     dma_q[$];
    exp_beat_t eb_q[$];
    exp_txn_t  et_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_req(input int r, input logic dc, input logic [15:0] data,
                            input logic last, input int gap);
        beat_t b;
        b = '{dc, data, last, gap};
        if (r == 0) cpu_q.push_back(b);
        else        dma_q.push_back(b);
    endtask

    task automatic exp_beat(input logic [1:0] owner, input logic dc,
                            input logic [15:0] data, input int rise_gap);
        exp_beat_t e;
        e = '{owner, dc, data, rise_gap};
        eb_q.push_back(e);
    endtask

    task automatic exp_txn(input logic [1:0] owner, input int len);
        exp_txn_t t;
        t = '{owner, len};
        et_q.push_back(t);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && !(cpu_q.size() == 0 && dma_q.size() == 0 && eb_q.size() == 0 &&
                               et_q.size() == 0 && bus.busy == 1'b0)) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_done: still busy after %0d cycles, expected idle", name, budget);
        end
    endtask

    task automatic wait_cs_fall(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && bus.lcd_cs_n !== 1'b0) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL %s_cs_fall: cs_n still 1 after %0d cycles, expected 0", name, budget);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    // Requester models: present the queue head, pop it once the handshake completes.
    initial begin : drivers
        logic [1:0] xf;
        int         gap_cnt [2];
        bus.req_valid = 2'b00;
        bus.req_dc    = 2'b00;
        bus.req_last  = 2'b00;
        bus.req_data0 = 16'h0;
        bus.req_data1 = 16'h0;
        gap_cnt[0] = 0;
        gap_cnt[1] = 0;
        forever begin
            @(negedge clk);
            xf = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            if (xf[0] && cpu_q.size() > 0) begin
                cpu_q.delete(0);
                gap_cnt[0] = 0;
            end
            if (xf[1] && dma_q.size() > 0) begin
                dma_q.delete(0);
                gap_cnt[1] = 0;
            end
            if (cpu_q.size() == 0) begin
                bus.req_valid[0] = 1'b0;
                gap_cnt[0] = 0;
            end else if (gap_cnt[0] >= cpu_q[0].gap) begin
                bus.req_valid[0] = 1'b1;
                bus.req_dc[0]    = cpu_q[0].dc;
                bus.req_last[0]  = cpu_q[0].last;
                bus.req_data0    = cpu_q[0].data;
            end else begin
                bus.req_valid[0] = 1'b0;
                gap_cnt[0]++;
            end
            if (dma_q.size() == 0) begin
                bus.req_valid[1] = 1'b0;
                gap_cnt[1] = 0;
            end else if (gap_cnt[1] >= dma_q[0].gap) begin
                bus.req_valid[1] = 1'b1;
                bus.req_dc[1]    = dma_q[0].dc;
                bus.req_last[1]  = dma_q[0].last;
                bus.req_data1    = dma_q[0].data;
            end else begin
                bus.req_valid[1] = 1'b0;
                gap_cnt[1]++;
            end
        end
    end

    initial begin : monitor
        logic        prev_wr;
        logic        prev_cs;
        logic [15:0] prev_data;
        logic [1:0]  cs_grant;
        int          cs_cnt;
        int          cyc;
        int          last_rise;
        exp_beat_t   eb;
        exp_txn_t    et;
        prev_wr   = 1'b1;
        prev_cs   = 1'b1;
        prev_data = 16'h0;
        cs_grant  = 2'b00;
        cs_cnt    = 0;
        cyc       = 0;
        last_rise = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (!prev_wr && bus.lcd_wr_n) begin
                    if (eb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: data %0h strobed, expected no beat", bus.lcd_data);
                    end else begin
                        eb = eb_q.pop_front();
                        check("beat_data", 32'(bus.lcd_data), 32'(eb.data));
                        check("beat_hold", 32'(prev_data), 32'(eb.data));
                        check("beat_dc", 32'(bus.lcd_d_c_n), 32'(eb.dc));
                        check("beat_grant", 32'(bus.grant), 32'(eb.owner));
                        if (eb.rise_gap != 0)
                            check("beat_spacing", 32'(cyc - last_rise), 32'(eb.rise_gap));
                    end
                    last_rise = cyc;
                end
                if (!bus.lcd_cs_n) begin
                    cs_cnt++;
                    cs_grant = bus.grant;
                end
                if (!prev_cs && bus.lcd_cs_n) begin
                    if (et_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_txn: cs_n frame of %0d cycles, expected none", cs_cnt);
                    end else begin
                        et = et_q.pop_front();
                        check("txn_cs_len", 32'(cs_cnt), 32'(et.cs_len));
                        check("txn_grant", 32'(cs_grant), 32'(et.owner));
                        check("txn_end_idle", 32'({bus.grant, bus.busy}), 32'(3'b000));
                    end
                    cs_cnt = 0;
                end
            end else begin
                cs_cnt = 0;
            end
            prev_wr   = bus.lcd_wr_n;
            prev_cs   = bus.lcd_cs_n;
            prev_data = bus.lcd_data;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [6:0]  t1_cs, t1_wr, t1_rdy;
        logic [10:0] t6_cs, t6_wr, t6_rdy;
        bit          drop;
        int          n;

        reset          = 1'b1;
        bus2.req_valid = 2'b00;
        bus2.req_dc    = 2'b00;
        bus2.req_last  = 2'b00;
        bus2.req_data0 = 16'h0;
        bus2.req_data1 = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_cs_n", 32'(bus.lcd_cs_n), 32'd1);
        check("rst_wr_n", 32'(bus.lcd_wr_n), 32'd1);
        check("rst_d_c_n", 32'(bus.lcd_d_c_n), 32'd1);
        check("rst_data", 32'(bus.lcd_data), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // CPU single command, default timing, cycle by cycle
        push_req(0, 1'b0, 16'h002C, 1'b1, 0);
        exp_beat(2'b01, 1'b0, 16'h002C, 0);
        exp_txn(2'b01, 6);
        t1_cs  = 7'b1000000;
        t1_wr  = 7'b1111001;
        t1_rdy = 7'b0000001;
        wait_cs_fall("t1", 20);
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("t1_cs_c%0d", c), 32'(bus.lcd_cs_n), 32'(t1_cs[c-1]));
            check($sformatf("t1_wr_c%0d", c), 32'(bus.lcd_wr_n), 32'(t1_wr[c-1]));
            check($sformatf("t1_rdy_c%0d", c), 32'(bus.req_ready), 32'(t1_rdy[c-1]));
            if (c >= 2) begin
                check($sformatf("t1_data_c%0d", c), 32'(bus.lcd_data), 32'h002C);
                check($sformatf("t1_dc_c%0d", c), 32'(bus.lcd_d_c_n), 32'd0);
            end
            if (c < 7) @(negedge clk);
        end
        wait_done("t1", 50);

        // DMA 4-beat burst, valid held high
        push_req(1, 1'b1, 16'h1111, 1'b0, 0);
        push_req(1, 1'b1, 16'h2222, 1'b0, 0);
        push_req(1, 1'b1, 16'h3333, 1'b0, 0);
        push_req(1, 1'b1, 16'h4444, 1'b1, 0);
        exp_beat(2'b10, 1'b1, 16'h1111, 0);
        exp_beat(2'b10, 1'b1, 16'h2222, 4);
        exp_beat(2'b10, 1'b1, 16'h3333, 4);
        exp_beat(2'b10, 1'b1, 16'h4444, 4);
        exp_txn(2'b10, 18);
        wait_done("t2", 100);

        // Ties: CPU first after reset, then alternation
        pulse_reset();
        push_req(0, 1'b0, 16'h0A0A, 1'b1, 0);
        push_req(1, 1'b1, 16'hB0B0, 1'b1, 0);
        exp_beat(2'b01, 1'b0, 16'h0A0A, 0);
        exp_txn(2'b01, 6);
        exp_beat(2'b10, 1'b1, 16'hB0B0, 0);
        exp_txn(2'b10, 6);
        wait_done("t3a", 60);
        push_req(0, 1'b0, 16'h0C0C, 1'b1, 0);
        push_req(1, 1'b1, 16'h0D0D, 1'b1, 0);
        exp_beat(2'b01, 1'b0, 16'h0C0C, 0);
        exp_txn(2'b01, 6);
        exp_beat(2'b10, 1'b1, 16'h0D0D, 0);
        exp_txn(2'b10, 6);
        wait_done("t3b", 60);
        push_req(0, 1'b0, 16'h0E0E, 1'b1, 0);
        exp_beat(2'b01, 1'b0, 16'h0E0E, 0);
        exp_txn(2'b01, 6);
        wait_done("t3c", 40);
        push_req(0, 1'b0, 16'h0F0F, 1'b1, 0);
        push_req(1, 1'b1, 16'h1717, 1'b1, 0);
        exp_beat(2'b10, 1'b1, 16'h1717, 0);
        exp_txn(2'b10, 6);
        exp_beat(2'b01, 1'b0, 16'h0F0F, 0);
        exp_txn(2'b01, 6);
        wait_done("t3d", 60);

        // DMA stalls 5 cycles before beat 3 while the CPU waits for the bus
        push_req(1, 1'b1, 16'h5555, 1'b0, 0);
        push_req(1, 1'b1, 16'h6666, 1'b0, 0);
        push_req(1, 1'b1, 16'h7777, 1'b1, 5);
        push_req(0, 1'b0, 16'h0099, 1'b1, 0);
        exp_beat(2'b10, 1'b1, 16'h5555, 0);
        exp_beat(2'b10, 1'b1, 16'h6666, 4);
        exp_beat(2'b10, 1'b1, 16'h7777, 6);
        exp_txn(2'b10, 16);
        exp_beat(2'b01, 1'b0, 16'h0099, 0);
        exp_txn(2'b01, 6);
        wait_cs_fall("t4", 20);
        repeat (9) @(negedge clk);
        check("t4_wait_cs", 32'(bus.lcd_cs_n), 32'd0);
        check("t4_wait_wr", 32'(bus.lcd_wr_n), 32'd1);
        check("t4_wait_grant", 32'(bus.grant), 32'b10);
        check("t4_wait_data", 32'(bus.lcd_data), 32'h6666);
        check("t4_wait_ready", 32'(bus.req_ready), 32'b10);
        wait_done("t4", 100);

        // Reset in the middle of LOW of a DMA burst
        push_req(1, 1'b1, 16'h8001, 1'b0, 0);
        push_req(1, 1'b1, 16'h8002, 1'b0, 0);
        push_req(1, 1'b1, 16'h8003, 1'b0, 0);
        push_req(1, 1'b1, 16'h8004, 1'b1, 0);
        wait_cs_fall("t5", 20);
        @(negedge clk);
        check("t5_in_low", 32'(bus.lcd_wr_n), 32'd0);
        mon_en = 1'b0;
        reset  = 1'b1;
        dma_q.delete();
        @(negedge clk);
        check("t5_abort_cs", 32'(bus.lcd_cs_n), 32'd1);
        check("t5_abort_wr", 32'(bus.lcd_wr_n), 32'd1);
        check("t5_abort_data", 32'(bus.lcd_data), 32'd0);
        check("t5_abort_dc", 32'(bus.lcd_d_c_n), 32'd1);
        check("t5_abort_grant", 32'(bus.grant), 32'd0);
        check("t5_abort_busy", 32'(bus.busy), 32'd0);
        check("t5_abort_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        push_req(1, 1'b1, 16'hBEEF, 1'b1, 0);
        exp_beat(2'b10, 1'b1, 16'hBEEF, 0);
        exp_txn(2'b10, 6);
        wait_cs_fall("t5b", 20);
        check("t5_regrant", 32'(bus.grant), 32'b10);
        check("t5_setup_ready", 32'(bus.req_ready), 32'b10);
        wait_done("t5", 50);

        // Non-default timing: CS_SETUP=3, WR_LOW=1, WR_HIGH=4, CS_HOLD=2
        t6_cs  = 11'b100_0000_0000;
        t6_wr  = 11'b111_1111_0111;
        t6_rdy = 11'b000_0000_0100;
        @(posedge clk);
        #1;
        bus2.req_valid = 2'b01;
        bus2.req_dc    = 2'b01;
        bus2.req_last  = 2'b01;
        bus2.req_data0 = 16'hA5A5;
        n = 0;
        @(negedge clk);
        while (n < 20 && bus2.lcd_cs_n !== 1'b0) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL t6_cs_fall: cs_n still 1 after 20 cycles, expected 0");
        end
        for (int c = 1; c <= 11; c++) begin
            check($sformatf("t6_cs_c%0d", c), 32'(bus2.lcd_cs_n), 32'(t6_cs[c-1]));
            check($sformatf("t6_wr_c%0d", c), 32'(bus2.lcd_wr_n), 32'(t6_wr[c-1]));
            check($sformatf("t6_rdy_c%0d", c), 32'(bus2.req_ready), 32'(t6_rdy[c-1]));
            if (c == 4) check("t6_data", 32'(bus2.lcd_data), 32'hA5A5);
            drop = bus2.req_ready[0];
            if (c < 11) begin
                @(posedge clk);
                #1;
                if (drop) bus2.req_valid = 2'b00;
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
